// File: rtl/ppu_timing.sv
// NES PPU raster timing: 341x262 dot/line counters, odd-frame dot skip,
// vblank/sprite status flags and the registered NMI line.
module ppu_timing #(
   parameter int HDOTS    = 341,
   parameter int VLINES   = 262,
   parameter int VBL_LINE = 241,
   parameter int PRE_LINE = 261
) (
   input  logic       clk_ppu,
   input  logic       reset_n,
   input  logic       render_en,
   input  logic       nmi_enable,
   input  logic       status_rd,
   input  logic       spr0_hit_set,
   input  logic       spr_ovf_set,
   output logic [8:0] ppu_hcnt,
   output logic [8:0] ppu_vcnt,
   output logic [2:0] status,
   output logic       nmi_n,
   output logic       frame_odd,
   output logic       visible,
   output logic       frame_start
);

   localparam logic [8:0] H_LAST = 9'(HDOTS - 1);
   localparam logic [8:0] H_SKIP = 9'(HDOTS - 2);
   localparam logic [8:0] V_LAST = 9'(VLINES - 1);
   localparam logic [8:0] V_VBL  = 9'(VBL_LINE);
   localparam logic [8:0] V_PRE  = 9'(PRE_LINE);

   logic [8:0] hcnt_q, hcnt_d;
   logic [8:0] vcnt_q, vcnt_d;
   logic       frame_odd_q, frame_odd_d;
   logic       vblank_q, vblank_d;
   logic       spr0_q, spr0_d;
   logic       ovf_q, ovf_d;
   logic       nmi_n_q, nmi_n_d;

   logic       odd_skip;
   logic       line_end;
   logic       frame_wrap;
   logic       vbl_set;
   logic       pre_clr;

   always_comb begin
      line_end   = (hcnt_q == H_LAST);
      // Odd frames drop the last dot of the pre-render line while rendering.
      odd_skip   = (vcnt_q == V_PRE) && (hcnt_q == H_SKIP) && frame_odd_q && render_en;
      frame_wrap = odd_skip || (line_end && (vcnt_q == V_LAST));
      vbl_set    = (vcnt_q == V_VBL) && (hcnt_q == 9'd1);
      pre_clr    = (vcnt_q == V_PRE) && (hcnt_q == 9'd1);
   end

   always_comb begin
      hcnt_d      = hcnt_q + 9'd1;
      vcnt_d      = vcnt_q;
      frame_odd_d = frame_odd_q;
      if (odd_skip) begin
         hcnt_d = '0;
         vcnt_d = '0;
      end else if (line_end) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? 9'd0 : vcnt_q + 9'd1;
      end
      if (frame_wrap) begin
         frame_odd_d = ~frame_odd_q;
      end
   end

   always_comb begin
      vblank_d = vblank_q;
      spr0_d   = spr0_q;
      ovf_d    = ovf_q;
      // A read in the set cycle wins, which suppresses vblank for the frame.
      if (pre_clr || status_rd) begin
         vblank_d = 1'b0;
      end else if (vbl_set) begin
         vblank_d = 1'b1;
      end
      if (pre_clr) begin
         spr0_d = 1'b0;
         ovf_d  = 1'b0;
      end else begin
         if (spr0_hit_set) spr0_d = 1'b1;
         if (spr_ovf_set)  ovf_d  = 1'b1;
      end
      nmi_n_d = ~(vblank_q & nmi_enable);
   end

   always_ff @(posedge clk_ppu or negedge reset_n) begin
      if (!reset_n) begin
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         frame_odd_q <= 1'b0;
         vblank_q    <= 1'b0;
         spr0_q      <= 1'b0;
         ovf_q       <= 1'b0;
         nmi_n_q     <= 1'b1;
      end else begin
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         frame_odd_q <= frame_odd_d;
         vblank_q    <= vblank_d;
         spr0_q      <= spr0_d;
         ovf_q       <= ovf_d;
         nmi_n_q     <= nmi_n_d;
      end
   end

   assign ppu_hcnt    = hcnt_q;
   assign ppu_vcnt    = vcnt_q;
   assign status      = {vblank_q, spr0_q, ovf_q};
   assign nmi_n       = nmi_n_q;
   assign frame_odd   = frame_odd_q;
   assign visible     = (vcnt_q < 9'd240) && (hcnt_q >= 9'd1) && (hcnt_q <= 9'd256);
   assign frame_start = (hcnt_q == 9'd0) && (vcnt_q == 9'd0);

endmodule
